// File: rtl/restoring_div4.sv
// Sequential restoring divider: DW-bit dividend / 4-bit divisor, one quotient bit per cycle,
// using a single fourbitsub. Define DIV_ZERO_DETECT_EN for the one-cycle divide-by-zero path.

module fourbitsub (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Bin,
    output logic [3:0] Difference,
    output logic       Bout
);
    logic [4:0] w_borrow;

    assign w_borrow[0] = Bin;

    // Ripple-borrow chain of full subtractors
    for (genvar i = 0; i < 4; i++) begin : g_fs
        assign Difference[i]  = A[i] ^ B[i] ^ w_borrow[i];
        assign w_borrow[i+1]  = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & w_borrow[i]);
    end

    assign Bout = w_borrow[4];
endmodule

module restoring_div4 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] Dividend,
    input  logic [3:0]    Divisor,
    output logic [DW-1:0] Quotient,
    output logic [3:0]    Remainder,
    output logic          busy,
    output logic          done,
    output logic          div_by_zero
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DW-1:0] r_n;
    logic [3:0]    r_d;
    logic [3:0]    r_r;
    logic [DW-1:0] r_q;
    logic [CW-1:0] r_cnt;
    logic          r_dz;

    logic          w_accept;
    logic          w_fast_zero;
    logic          w_last;
    logic [4:0]    w_s;
    logic [3:0]    w_diff;
    logic          w_bout;
    logic          w_take;
    logic [3:0]    w_r_next;

`ifdef DIV_ZERO_DETECT_EN
    assign w_fast_zero = (Divisor == 4'd0);
`else
    assign w_fast_zero = 1'b0;
`endif

    assign w_last = (r_cnt == '0);

    // One iteration: shift in the next dividend bit, trial-subtract the divisor
    assign w_s = {r_r, r_n[DW-1]};

    fourbitsub u_sub (
        .A          (w_s[3:0]),
        .B          (r_d),
        .Bin        (1'b0),
        .Difference (w_diff),
        .Bout       (w_bout)
    );

    // S[4] set means the shifted remainder is >= 16 > D, so the subtraction always fits
    assign w_take   = w_s[4] | ~w_bout;
    assign w_r_next = w_take ? w_diff : w_s[3:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = w_fast_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = w_fast_zero ? S_DONE : S_RUN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Working registers carry no reset; they are always loaded on accept before use
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_n   <= Dividend;
            r_d   <= Divisor;
            r_r   <= 4'd0;
            r_q   <= '0;
            r_cnt <= CW'(DW - 1);
        end else if (r_state == S_RUN) begin
            r_r   <= w_r_next;
            r_n   <= {r_n[DW-2:0], 1'b0};
            r_q   <= {r_q[DW-2:0], w_take};
            r_cnt <= r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Quotient  <= '0;
            Remainder <= 4'd0;
            r_dz      <= 1'b0;
        end else if (w_accept) begin
            r_dz <= w_fast_zero;
            if (w_fast_zero) begin
                Quotient  <= '1;
                Remainder <= Dividend[3:0];
            end
        end else if ((r_state == S_RUN) && w_last) begin
            Quotient  <= {r_q[DW-2:0], w_take};
            Remainder <= w_r_next;
        end
    end

    assign busy        = (r_state == S_RUN);
    assign done        = (r_state == S_DONE);
    assign div_by_zero = r_dz;
endmodule

// File: tb/tb_restoring_div4.sv
// Self-checking bench for restoring_div4: operation-level model plus directed literal checks.
module tb_restoring_div4;
    localparam int DW = 8;
`ifdef DIV_ZERO_DETECT_EN
    localparam bit DZEN = 1'b1;
`else
    localparam bit DZEN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic [DW-1:0] Dividend;
    logic [3:0]    Divisor;
    logic [DW-1:0] Quotient;
    logic [3:0]    Remainder;
    logic          busy;
    logic          done;
    logic          div_by_zero;

    int checks = 0;
    int errors = 0;

    restoring_div4 #(.DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .Dividend    (Dividend),
        .Divisor     (Divisor),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Operation-level model: an accepted request finishes DW edges later (or at once for a
    // detected zero divisor) with quotient/remainder from plain integer division.
    bit            m_run, m_done, m_dz, acc;
    int            m_left;
    logic [DW-1:0] m_q, p_q;
    logic [3:0]    m_r, p_r;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 0; m_done = 0; m_dz = 0; m_left = 0;
            m_q = '0; m_r = '0;
        end else begin
            acc    = start && !m_run;
            m_done = 0;
            if (m_run) begin
                m_left--;
                if (m_left == 0) begin
                    m_run = 0; m_done = 1; m_q = p_q; m_r = p_r;
                end
            end
            if (acc) begin
                m_dz = 0;
                if (Divisor == 4'd0) begin
                    p_q = '1;
                    p_r = Dividend[3:0];
                end else begin
                    p_q = Dividend / Divisor;
                    p_r = 4'(Dividend % Divisor);
                end
                if (DZEN && Divisor == 4'd0) begin
                    m_done = 1; m_q = p_q; m_r = p_r; m_dz = 1;
                end else begin
                    m_run = 1; m_left = DW;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, m_run);
        chk("done", done, m_done);
        chk("div_by_zero", div_by_zero, m_dz);
        chk("quotient", Quotient, m_q);
        chk("remainder", Remainder, m_r);
    end

    // Starts an operation (called #1 after an edge, from idle or a done cycle) and returns
    // #1 after the edge that raises done; lat counts cycles from accept to done inclusive.
    task automatic run_op(input logic [DW-1:0] a, input logic [3:0] d,
                          output int lat, output int nbusy);
        Dividend = a; Divisor = d; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; Dividend = ~a; Divisor = ~d;
        lat = 1; nbusy = 0;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic directed(input string nm, input logic [DW-1:0] a, input logic [3:0] d,
                            input int elat, input logic [DW-1:0] eq, input logic [3:0] er);
        int lat, nb;
        run_op(a, d, lat, nb);
        chk({nm, "_latency"}, lat, elat);
        chk({nm, "_busy_cycles"}, nb, elat - 1);
        chk({nm, "_q"}, Quotient, eq);
        chk({nm, "_r"}, Remainder, er);
    endtask

    initial begin
        int lat, nb, cyc;
        rst = 1'b1; start = 1'b0; Dividend = '0; Divisor = '0;
        #2;
        chk("rst_q", Quotient, 0);
        chk("rst_r", Remainder, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", div_by_zero, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        directed("basic_200_7", 8'd200, 4'd7, 9, 8'd28, 4'd4);
        directed("b_255_15", 8'd255, 4'd15, 9, 8'd17, 4'd0);
        directed("b_255_1", 8'd255, 4'd1, 9, 8'd255, 4'd0);
        directed("b_14_15", 8'd14, 4'd15, 9, 8'd0, 4'd14);
        directed("divzero", 8'hA5, 4'd0, DZEN ? 1 : 9, 8'hFF, 4'd5);
        chk("divzero_flag", div_by_zero, 32'(DZEN));

        // Start pulse while busy must be ignored
        Dividend = 8'd200; Divisor = 4'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 Dividend = 8'd100; Divisor = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("ignore_done_seen", done, 1);
        chk("ignore_q", Quotient, 28);
        chk("ignore_r", Remainder, 4);
        // Back-to-back accept from the done cycle
        directed("b2b_100_3", 8'd100, 4'd3, 9, 8'd33, 4'd1);

        // Reset during iteration 4
        Dividend = 8'd200; Divisor = 4'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_q", Quotient, 0);
        chk("midrst_r", Remainder, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_done", done, 0);
        end
        directed("after_rst_13_3", 8'd13, 4'd3, 9, 8'd4, 4'd1);

        // Exhaustive sweep over non-zero divisors
        for (int a = 0; a < 256; a++) begin
            for (int d = 1; d < 16; d++) begin
                run_op(8'(a), 4'(d), lat, nb);
                chk("sweep_q", Quotient, 32'(a / d));
                chk("sweep_r", Remainder, 32'(a % d));
            end
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
